// File: rtl/rmc_read_requester_if.sv
// Command, request-fifo, read-fifo and response signals between the host-side
// read requester and its surroundings (command source, cpu_rmc fifos, response sink).
interface rmc_read_requester_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [DATA_W-LEN_W-1:0] cmd_addr;
  logic [LEN_W-1:0]        cmd_len;
  logic [DATA_W-1:0]       req_fifo_data_in;
  logic                    req_fifo_enq;
  logic                    req_fifo_wrfull;
  logic [DATA_W-1:0]       read_fifo_data_out;
  logic                    read_fifo_deq;
  logic                    read_fifo_rdempty;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_W-1:0]       rsp_data;
  logic [LEN_W-1:0]        rsp_idx;
  logic                    rsp_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, req_fifo_wrfull,
           read_fifo_data_out, read_fifo_rdempty, rsp_ready,
    output cmd_ready, req_fifo_data_in, req_fifo_enq, read_fifo_deq,
           rsp_valid, rsp_data, rsp_idx, rsp_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, req_fifo_wrfull,
           read_fifo_data_out, read_fifo_rdempty, rsp_ready,
    input  cmd_ready, req_fifo_data_in, req_fifo_enq, read_fifo_deq,
           rsp_valid, rsp_data, rsp_idx, rsp_last
  );
endinterface

// File: rtl/rmc_read_requester.sv
// Host-side read requester for cpu_rmc: packs read commands into request words,
// then frames the returned data words per command (index, last) on a valid/ready port.
module rmc_read_requester #(
  parameter int DATA_W          = 32,
  parameter int LEN_W           = 8,
  parameter int MAX_WORDS       = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PTR_W          = $clog2(MAX_OUTSTANDING),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  rmc_read_requester_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     outstanding,
  output logic                 err_len,
  output logic                 err_stray
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t           state, state_next;
  logic [LEN_W-1:0] len_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [LEN_W-1:0] idx, idx_next, head_len;
  logic             len_ok, accept, push, pop, stray;

  // cmd_ready is forced low while reset is asserted so nothing can be accepted or enqueued.
  assign len_ok                = (bus.cmd_len != '0) && (bus.cmd_len <= LEN_W'(MAX_WORDS));
  assign bus.cmd_ready         = rstn && !bus.req_fifo_wrfull && (count < CNT_W'(MAX_OUTSTANDING));
  assign accept                = bus.cmd_valid && bus.cmd_ready;
  assign push                  = accept && len_ok;
  assign bus.req_fifo_enq      = push;
  assign bus.req_fifo_data_in  = push ? {bus.cmd_len, bus.cmd_addr} : '0;
  assign head_len              = len_q[rd_ptr];
  assign outstanding           = count;
  assign busy                  = (count != '0);

  always_comb begin
    state_next         = state;
    idx_next           = idx;
    pop                = 1'b0;
    stray              = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_data       = '0;
    bus.rsp_idx        = '0;
    bus.rsp_last       = 1'b0;
    bus.read_fifo_deq  = 1'b0;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (count != '0 || push) begin
          state_next = STREAM;
        end
        // A word arriving with nothing in flight has no owner and is drained.
        if (rstn && count == '0 && !bus.read_fifo_rdempty) begin
          bus.read_fifo_deq = 1'b1;
          stray             = 1'b1;
        end
      end
      STREAM: begin
        if (!bus.read_fifo_rdempty) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_data  = bus.read_fifo_data_out;
        end
        bus.rsp_idx  = idx;
        bus.rsp_last = (idx == head_len - LEN_W'(1));
        if (bus.rsp_valid && bus.rsp_ready) begin
          bus.read_fifo_deq = 1'b1;
          if (bus.rsp_last) begin
            pop      = 1'b1;
            idx_next = '0;
            // Stay in STREAM without a bubble when another command is queued or arriving.
            if (count == CNT_W'(1) && !push) begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx + LEN_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      err_len   <= 1'b0;
      err_stray <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      count     <= count + CNT_W'(push) - CNT_W'(pop);
      err_len   <= accept && !len_ok;
      err_stray <= stray;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Length storage needs no reset: emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      len_q[wr_ptr] <= bus.cmd_len;
    end
  end

endmodule

// File: tb/tb_rmc_read_requester.sv
// Directed, table-driven bench for rmc_read_requester: each vector is one clock cycle
// of inputs plus the hand-computed outputs expected during that cycle.
module tb_rmc_read_requester;

  typedef struct {
    logic        cv;
    logic [23:0] addr;
    logic [7:0]  len;
    logic        wf;
    logic        re;
    logic [31:0] rd;
    logic        rr;
    logic        cr;
    logic        enq;
    logic [31:0] reqd;
    logic        deq;
    logic        rv;
    logic [31:0] rdata;
    logic [7:0]  idx;
    logic        last;
    logic        busy;
    logic [2:0]  outs;
    logic        el;
    logic        es;
  } vec_t;

  logic       clk;
  logic       rstn;
  logic       busy;
  logic [2:0] outstanding;
  logic       err_len;
  logic       err_stray;
  int         n_checks;
  int         n_pass;
  int         vec_num;
  vec_t       tbl[$];

  rmc_read_requester_if #(.DATA_W(32), .LEN_W(8)) bus ();

  rmc_read_requester #(
    .DATA_W(32), .LEN_W(8), .MAX_WORDS(8), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .busy(busy),
    .outstanding(outstanding), .err_len(err_len), .err_stray(err_stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int cv, input int addr, input int len, input int wf,
                              input int re, input int rd, input int rr, input int cr,
                              input int enq, input int reqd, input int deq, input int rv,
                              input int rdata, input int idx, input int last, input int bsy,
                              input int outs, input int el, input int es);
    vec_t v;
    v.cv = cv[0];   v.addr = addr[23:0]; v.len = len[7:0];  v.wf = wf[0];
    v.re = re[0];   v.rd = rd;           v.rr = rr[0];      v.cr = cr[0];
    v.enq = enq[0]; v.reqd = reqd;       v.deq = deq[0];    v.rv = rv[0];
    v.rdata = rdata; v.idx = idx[7:0];   v.last = last[0];  v.busy = bsy[0];
    v.outs = outs[2:0]; v.el = el[0];    v.es = es[0];
    return v;
  endfunction

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL vec%0d %s: got 0x%0h, expected 0x%0h", vec_num, name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic checkOutput(input vec_t v);
    checkField("cmd_ready",   32'(bus.cmd_ready),        32'(v.cr));
    checkField("req_enq",     32'(bus.req_fifo_enq),     32'(v.enq));
    checkField("req_data",    bus.req_fifo_data_in,      v.reqd);
    checkField("read_deq",    32'(bus.read_fifo_deq),    32'(v.deq));
    checkField("rsp_valid",   32'(bus.rsp_valid),        32'(v.rv));
    checkField("rsp_data",    bus.rsp_data,              v.rdata);
    checkField("rsp_idx",     32'(bus.rsp_idx),          32'(v.idx));
    checkField("rsp_last",    32'(bus.rsp_last),         32'(v.last));
    checkField("busy",        32'(busy),                 32'(v.busy));
    checkField("outstanding", 32'(outstanding),          32'(v.outs));
    checkField("err_len",     32'(err_len),              32'(v.el));
    checkField("err_stray",   32'(err_stray),            32'(v.es));
  endtask

  // Drive one cycle of inputs after the falling edge, then compare before the next rising edge.
  task automatic applyStimulus(input vec_t v, input logic rst_level = 1'b1);
    @(negedge clk);
    rstn                   = rst_level;
    bus.cmd_valid          = v.cv;
    bus.cmd_addr           = v.addr;
    bus.cmd_len            = v.len;
    bus.req_fifo_wrfull    = v.wf;
    bus.read_fifo_rdempty  = v.re;
    bus.read_fifo_data_out = v.rd;
    bus.rsp_ready          = v.rr;
    #1;
    checkOutput(v);
    vec_num++;
  endtask

  initial begin
    vec_t zero_v;
    vec_t idle_v;
    n_checks = 0;
    n_pass   = 0;
    vec_num  = 0;
    rstn                   = 1'b0;
    bus.cmd_valid          = 1'b0;
    bus.cmd_addr           = '0;
    bus.cmd_len            = '0;
    bus.req_fifo_wrfull    = 1'b0;
    bus.read_fifo_rdempty  = 1'b1;
    bus.read_fifo_data_out = '0;
    bus.rsp_ready          = 1'b0;

    idle_v = mk(0,0,0,0,1,0,1, 1,0,0,0,0,0,0,0,0,0,0,0);

    // Reset: a pending read word and a command must both be ignored.
    zero_v = mk(1,'h33,1,0,0,'h1234,1, 0,0,0,0,0,0,0,0,0,0,0,0);
    applyStimulus(zero_v, 1'b0);

    // Single command of 3 words.
    tbl.push_back(mk(1,'h10,3,0,1,0,1,          1,1,'h03000010,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,             1,0,0,0,0,0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'hA0A00001,1,    1,0,0,1,1,'hA0A00001,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'hB0B00002,1,    1,0,0,1,1,'hB0B00002,1,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'hC0C00003,1,    1,0,0,1,1,'hC0C00003,2,1,1,1,0,0));
    tbl.push_back(idle_v);
    // Illegal lengths 0 and 9, then request fifo full.
    tbl.push_back(mk(1,'h20,0,0,1,0,1,          1,0,0,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,'h21,9,0,1,0,1,          1,0,0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(mk(1,'h22,1,1,1,0,1,          0,0,0,0,0,0,0,0,0,0,1,0));
    tbl.push_back(idle_v);
    // Stray word with no command in flight.
    tbl.push_back(mk(0,0,0,0,0,'hDEADBEEF,1,    1,0,0,1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,             1,0,0,0,0,0,0,0,0,0,0,1));
    tbl.push_back(idle_v);
    // Back-to-back len=2 commands stream without a bubble.
    tbl.push_back(mk(1,'h40,2,0,1,0,1,          1,1,'h02000040,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,'h50,2,0,1,0,1,          1,1,'h02000050,0,0,0,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'h11,1,          1,0,0,1,1,'h11,0,0,1,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,'h22,1,          1,0,0,1,1,'h22,1,1,1,2,0,0));
    tbl.push_back(mk(0,0,0,0,0,'h33,1,          1,0,0,1,1,'h33,0,0,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'h44,1,          1,0,0,1,1,'h44,1,1,1,1,0,0));
    tbl.push_back(idle_v);
    // New command accepted in the same cycle as the last word of the previous one.
    tbl.push_back(mk(1,'h60,1,0,1,0,1,          1,1,'h01000060,0,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,'h70,1,0,0,'h66,1,       1,1,'h01000070,1,1,'h66,0,1,1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,'h77,1,          1,0,0,1,1,'h77,0,1,1,1,0,0));
    tbl.push_back(idle_v);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
    end

    // Outstanding limit: four len=1 commands fill the queue, the fifth waits for a response.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(1,'h100+i,1,0,1,0,0, 1,1,'h01000100+i,0,0,0,0,
                       (i > 0) ? 1 : 0,(i > 0) ? 1 : 0,i,0,0));
    end
    applyStimulus(mk(1,'h104,1,0,1,0,0,          0,0,0,0,0,0,0,1,1,4,0,0));
    applyStimulus(mk(1,'h104,1,0,0,'h50000000,0, 0,0,0,0,1,'h50000000,0,1,1,4,0,0));
    applyStimulus(mk(1,'h104,1,0,0,'h50000000,1, 0,0,0,1,1,'h50000000,0,1,1,4,0,0));
    applyStimulus(mk(1,'h104,1,0,0,'h50000001,0, 1,1,'h01000104,0,1,'h50000001,0,1,1,3,0,0));
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(mk(0,0,0,0,0,'h50000000+j,1, (j == 1) ? 0 : 1,0,0,1,1,'h50000000+j,0,1,1,5-j,0,0));
    end
    applyStimulus(idle_v);

    // Reset after the first of three words; everything clears and a fresh command frames from 0.
    applyStimulus(mk(1,'h90,3,0,1,0,1,          1,1,'h03000090,0,0,0,0,0,0,0,0,0));
    applyStimulus(mk(0,0,0,0,0,'hA1,1,          1,0,0,1,1,'hA1,0,0,1,1,0,0));
    applyStimulus(mk(1,'h91,2,0,0,'hB1,1,       0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
    applyStimulus(mk(1,'h80,2,0,1,0,1,          1,1,'h02000080,0,0,0,0,0,0,0,0,0));
    applyStimulus(mk(0,0,0,0,0,'hF1,1,          1,0,0,1,1,'hF1,0,0,1,1,0,0));
    applyStimulus(mk(0,0,0,0,0,'hF2,1,          1,0,0,1,1,'hF2,1,1,1,1,0,0));
    applyStimulus(idle_v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
